// File: rtl/demux_shift_arb_if.sv
// demux_shift_arb_if: request/length/serial-gating bundle between a requester and demux_shift_arb.
// Abort/Aborted exist only when DEMUX_ARB_ABORT_EN is defined.
interface demux_shift_arb_if #(parameter int LEN_W = 5);
  logic [1:0] Req;
  logic [LEN_W-1:0] Len0;
  logic [LEN_W-1:0] Len1;
  logic Data_valid;
  logic Sel;
  logic Shift_en;
  logic [1:0] Gnt;
  logic [1:0] Done;
  logic Busy;
  logic [LEN_W:0] Bit_cnt;
`ifdef DEMUX_ARB_ABORT_EN
  logic Abort;
  logic Aborted;
`endif
  modport master (
`ifdef DEMUX_ARB_ABORT_EN
    output Abort,
    input Aborted,
`endif
    output Req, Len0, Len1, Data_valid,
    input Sel, Shift_en, Gnt, Done, Busy, Bit_cnt
  );
  modport slave (
`ifdef DEMUX_ARB_ABORT_EN
    input Abort,
    output Aborted,
`endif
    input Req, Len0, Len1, Data_valid,
    output Sel, Shift_en, Gnt, Done, Busy, Bit_cnt
  );
endinterface

// File: rtl/demux_shift_arb.sv
// demux_shift_arb: round-robin arbiter that routes length-counted serial bursts to one of two demux outputs.
// Optional Abort/Aborted handshake is enabled by defining DEMUX_ARB_ABORT_EN.
module demux_shift_arb #(parameter int LEN_W = 5) (
  input logic Clk,
  input logic Rst_n,
  demux_shift_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, SHIFT, DONE} state_t;
  state_t state;
  logic last;
  logic win;
  logic abort;
  logic last_bit;
  logic [LEN_W:0] len_win;
`ifdef DEMUX_ARB_ABORT_EN
  assign abort = bus.Abort && (state == GRANT || state == SHIFT);
`else
  assign abort = 1'b0;
`endif
  assign win = &bus.Req ? ~last : bus.Req[1];
  // a zero length field means the full 2^LEN_W bits
  assign len_win = win ? {bus.Len1 == '0, bus.Len1} : {bus.Len0 == '0, bus.Len0};
  assign last_bit = bus.Bit_cnt == (LEN_W+1)'(1);
  assign bus.Shift_en = state == SHIFT && bus.Data_valid && !abort;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      bus.Sel <= 1'b0;
      bus.Gnt <= '0;
      bus.Done <= '0;
      bus.Busy <= 1'b0;
      bus.Bit_cnt <= '0;
    end else begin
      bus.Done <= '0;
      if (abort) begin
        state <= IDLE;
        last <= bus.Sel;
        bus.Gnt <= '0;
        bus.Busy <= 1'b0;
        bus.Bit_cnt <= '0;
      end else
        case (state)
          IDLE: if (|bus.Req) begin
            state <= GRANT;
            bus.Sel <= win;
            bus.Gnt <= win ? 2'b10 : 2'b01;
            bus.Busy <= 1'b1;
            bus.Bit_cnt <= len_win;
          end
          GRANT: state <= SHIFT;
          SHIFT: if (bus.Data_valid) begin
            bus.Bit_cnt <= bus.Bit_cnt - 1'b1;
            if (last_bit) begin
              state <= DONE;
              bus.Done <= bus.Gnt;
            end
          end
          DONE: begin
            state <= IDLE;
            last <= bus.Sel;
            bus.Gnt <= '0;
            bus.Busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
    end
`ifdef DEMUX_ARB_ABORT_EN
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) bus.Aborted <= 1'b0;
    else bus.Aborted <= abort;
`endif
endmodule
